// File: rtl/contador_bcd_multi_if.sv
// Bus bundle for the multi-digit BCD counter.
// Controls are level/strobe signals, not a valid/ready handshake. While en is high, each
// clk edge takes one counting step. Each clk edge with load high is one load request. The
// counter accepts every request in the cycle it appears, and load_err flags a rejected load
// one cycle later.
interface contador_bcd_multi_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  carry;
    logic                  zero;
    logic                  load_err;

    // Driver side: owns the controls and observes the count.
    modport master (
        output en, up, load, load_val,
        input  bcd, carry, zero, load_err
    );

    // Counter side: consumes the controls and produces the count and flags.
    modport slave (
        input  en, up, load, load_val,
        output bcd, carry, zero, load_err
    );
endinterface

// File: rtl/contador_bcd_multi.sv
// Multi-digit synchronous BCD up/down counter with a programmable limit, wrap or saturate
// at the ends of the range, and validated parallel load. carry marks the terminal step so
// that a downstream counter's enable can be chained to it.
module contador_bcd_multi #(
    parameter int                  DIGITS   = 2,
    parameter logic [4*DIGITS-1:0] LIMIT    = 8'h99,
    parameter bit                  SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    contador_bcd_multi_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    // True when every nibble of v is a decimal digit.
    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    if (!is_bcd(LIMIT) || LIMIT == '0) begin : g_bad_limit
        $error("contador_bcd_multi: LIMIT must be nonzero valid BCD");
    end

    logic [W-1:0] bcd_q;
    logic         load_err_q;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         at_top;
    logic         at_zero;
    logic         load_ok;

    assign at_top  = (bcd_q == LIMIT);
    assign at_zero = (bcd_q == '0);
    // Ordering of BCD vectors matches ordering of their decimal values, so a plain compare works.
    assign load_ok = is_bcd(bus.load_val) && (bus.load_val <= LIMIT);

    // Decimal increment: ripple a carry from digit 0, rolling 9 -> 0.
    always_comb begin
        logic c;
        c       = 1'b1;
        inc_val = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (bcd_q[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
    end

    // Decimal decrement: ripple a borrow from digit 0, rolling 0 -> 9.
    always_comb begin
        logic b;
        b       = 1'b1;
        dec_val = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (bcd_q[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = bcd_q[4*k +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
    end

    // Count register: reset beats load, and load beats en. A rejected load holds the count and pulses load_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            if (bus.load) begin
                if (load_ok) bcd_q      <= bus.load_val;
                else         load_err_q <= 1'b1;
            end else if (bus.en) begin
                if (bus.up) begin
                    if (!at_top)        bcd_q <= inc_val;
                    else if (!SATURATE) bcd_q <= '0;
                end else begin
                    if (!at_zero)       bcd_q <= dec_val;
                    else if (!SATURATE) bcd_q <= LIMIT;
                end
            end
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.load_err = load_err_q;
    assign bus.zero     = at_zero;
    // Terminal-count flag in the same cycle as the wrapping (or held) step.
    assign bus.carry    = bus.en & ~bus.load & ~reset & (bus.up ? at_top : at_zero);
endmodule

// File: tb/tb_contador_bcd_multi.sv
// Directed bench for contador_bcd_multi: seconds counter (wrap at 59), saturating 0..99
// counter, and a two-stage single-digit cascade measured against a 2-digit reference.
module tb_contador_bcd_multi;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    contador_bcd_multi_if #(.DIGITS(2)) if_sec ();
    contador_bcd_multi_if #(.DIGITS(2)) if_sat ();
    contador_bcd_multi_if #(.DIGITS(1)) if_lo ();
    contador_bcd_multi_if #(.DIGITS(1)) if_hi ();
    contador_bcd_multi_if #(.DIGITS(2)) if_ref ();

    contador_bcd_multi #(.DIGITS(2), .LIMIT(8'h59), .SATURATE(1'b0))
        u_sec (.clk(clk), .reset(reset), .bus(if_sec));
    contador_bcd_multi #(.DIGITS(2), .LIMIT(8'h99), .SATURATE(1'b1))
        u_sat (.clk(clk), .reset(reset), .bus(if_sat));
    contador_bcd_multi #(.DIGITS(1), .LIMIT(4'h9), .SATURATE(1'b0))
        u_lo (.clk(clk), .reset(reset), .bus(if_lo));
    contador_bcd_multi #(.DIGITS(1), .LIMIT(4'h9), .SATURATE(1'b0))
        u_hi (.clk(clk), .reset(reset), .bus(if_hi));
    contador_bcd_multi #(.DIGITS(2), .LIMIT(8'h99), .SATURATE(1'b0))
        u_ref (.clk(clk), .reset(reset), .bus(if_ref));

    // Cascade: the tens digit steps only on the units digit's terminal count.
    assign if_hi.en       = if_lo.carry;
    assign if_hi.up       = if_lo.up;
    assign if_hi.load     = 1'b0;
    assign if_hi.load_val = 4'h0;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic sec_load(input logic [7:0] v);
        if_sec.load     = 1'b1;
        if_sec.load_val = v;
        step();
        if_sec.load     = 1'b0;
    endtask

    task automatic sat_load(input logic [7:0] v);
        if_sat.load     = 1'b1;
        if_sat.load_val = v;
        step();
        if_sat.load     = 1'b0;
    endtask

    initial begin
        int m;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        if_sec.en = 0; if_sec.up = 1; if_sec.load = 0; if_sec.load_val = '0;
        if_sat.en = 0; if_sat.up = 1; if_sat.load = 0; if_sat.load_val = '0;
        if_lo.en  = 0; if_lo.up  = 1; if_lo.load  = 0; if_lo.load_val  = '0;
        if_ref.en = 0; if_ref.up = 1; if_ref.load = 0; if_ref.load_val = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_bcd", 16'(if_sec.bcd), 16'h00);
        check("rst_zero", 16'(if_sec.zero), 16'h1);
        check("rst_carry", 16'(if_sec.carry), 16'h0);
        check("rst_lerr", 16'(if_sec.load_err), 16'h0);

        // Seconds counter: 00..59 then back to 00, carry only at 59
        if_sec.en = 1; if_sec.up = 1;
        #1;
        for (int i = 0; i < 60; i++) begin
            check("sec_bcd", 16'(if_sec.bcd), 16'(to_bcd2(i)));
            check("sec_carry", 16'(if_sec.carry), 16'(i == 59));
            check("sec_zero", 16'(if_sec.zero), 16'(i == 0));
            step();
        end
        check("sec_wrap", 16'(if_sec.bcd), 16'h00);
        if_sec.en = 0;

        // Load 09, one up step -> 10
        sec_load(8'h09);
        check("ld09", 16'(if_sec.bcd), 16'h09);
        if_sec.en = 1; if_sec.up = 1;
        step();
        if_sec.en = 0;
        check("up_09_10", 16'(if_sec.bcd), 16'h10);
        // Down step with a borrow: 10 -> 09
        if_sec.en = 1; if_sec.up = 0;
        step();
        if_sec.en = 0;
        check("dn_10_09", 16'(if_sec.bcd), 16'h09);
        // Load 00, down step wraps to LIMIT with carry
        sec_load(8'h00);
        check("ld00", 16'(if_sec.bcd), 16'h00);
        if_sec.en = 1; if_sec.up = 0;
        #1;
        check("dn_carry", 16'(if_sec.carry), 16'h1);
        step();
        check("dn_wrap", 16'(if_sec.bcd), 16'h59);
        check("dn_nocarry", 16'(if_sec.carry), 16'h0);
        step();
        if_sec.en = 0;
        check("dn_59_58", 16'(if_sec.bcd), 16'h58);

        // Rejected loads: invalid digit, then above LIMIT
        sec_load(8'h09);
        sec_load(8'h3A);
        check("bad_digit_err", 16'(if_sec.load_err), 16'h1);
        check("bad_digit_hold", 16'(if_sec.bcd), 16'h09);
        step();
        check("bad_digit_pulse", 16'(if_sec.load_err), 16'h0);
        sec_load(8'h75);
        check("over_lim_err", 16'(if_sec.load_err), 16'h1);
        check("over_lim_hold", 16'(if_sec.bcd), 16'h09);
        step();
        check("over_lim_pulse", 16'(if_sec.load_err), 16'h0);
        sec_load(8'h59);
        check("ld_at_lim", 16'(if_sec.bcd), 16'h59);
        check("ld_at_lim_err", 16'(if_sec.load_err), 16'h0);

        // Reset overrides load and en
        sec_load(8'h42);
        check("ld42", 16'(if_sec.bcd), 16'h42);
        reset = 1; if_sec.load = 1; if_sec.load_val = 8'h15; if_sec.en = 1; if_sec.up = 1;
        #1;
        check("rst_gates_carry", 16'(if_sec.carry), 16'h0);
        step();
        reset = 0; if_sec.load = 0; if_sec.en = 0;
        check("rst_mid_bcd", 16'(if_sec.bcd), 16'h00);
        check("rst_mid_zero", 16'(if_sec.zero), 16'h1);
        check("rst_mid_lerr", 16'(if_sec.load_err), 16'h0);
        // Load beats en, and load masks carry
        if_sec.load = 1; if_sec.load_val = 8'h30; if_sec.en = 1; if_sec.up = 0;
        #1;
        check("load_gates_carry", 16'(if_sec.carry), 16'h0);
        step();
        if_sec.load = 0; if_sec.en = 0;
        check("load_wins", 16'(if_sec.bcd), 16'h30);

        // Saturating counter: holds at 99 going up, at 00 going down
        sat_load(8'h98);
        if_sat.en = 1; if_sat.up = 1;
        #1;
        check("sat_98_carry", 16'(if_sat.carry), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat_hold99", 16'(if_sat.bcd), 16'h99);
            check("sat_carry99", 16'(if_sat.carry), 16'h1);
        end
        if_sat.en = 0;
        sat_load(8'h00);
        if_sat.en = 1; if_sat.up = 0;
        #1;
        check("sat_carry00", 16'(if_sat.carry), 16'h1);
        step();
        check("sat_hold00_a", 16'(if_sat.bcd), 16'h00);
        step();
        check("sat_hold00_b", 16'(if_sat.bcd), 16'h00);
        if_sat.en = 0;

        // Cascade vs 2-digit reference vs bench model
        reset = 1;
        step();
        reset = 0;
        if_lo.en = 1; if_lo.up = 1;
        if_ref.en = 1; if_ref.up = 1;
        m = 0;
        for (int i = 0; i < 110; i++) begin
            check("casc_pair", 16'({if_hi.bcd, if_lo.bcd}), 16'(to_bcd2(m)));
            check("casc_ref", 16'(if_ref.bcd), 16'(to_bcd2(m)));
            step();
            m = (m + 1) % 100;
        end
        if_lo.en = 0; if_ref.en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
